// File: rtl/cl_serial_ctrl.sv
// Bit-serial logic unit controller: feeds operands LSB-first through a single
// one-bit logic cell and assembles the WIDTH-bit result with a busy/done handshake.
module cl_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // The one shared single-bit logic cell.
    function automatic logic cell_fn(input logic a_bit, input logic b_bit, input logic [1:0] op_code);
        logic r;
        case (op_code)
            2'b00:   r = a_bit & b_bit;
            2'b01:   r = a_bit | b_bit;
            2'b10:   r = a_bit ^ b_bit;
            2'b11:   r = ~a_bit;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] out_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             last_s;
    logic             cell_bit_s;
    logic [WIDTH-1:0] result_next_s;
    logic [1:0]       next_state_s;

    // Accept/complete decode, cell evaluation and next-state selection.
    always_comb begin
        accept_s      = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        last_s        = (state_r == ST_RUN) && (cnt_r == CNT_LAST);
        cell_bit_s    = cell_fn(a_sh_r[0], b_sh_r[0], op_r);
        result_next_s = {cell_bit_s, res_sh_r[WIDTH-1:1]};
        next_state_s  = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) next_state_s = ST_RUN;
                else          next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) next_state_s = ST_DONE;
                else        next_state_s = ST_RUN;
            end
            ST_DONE: begin
                if (accept_s) next_state_s = ST_RUN;
                else          next_state_s = ST_IDLE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, operand shifters, counter and the registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_sh_r <= '0;
            op_r     <= 2'b00;
            out_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_RUN);
            done_r  <= (next_state_s == ST_DONE);
            if (accept_s) begin
                a_sh_r <= a;
                b_sh_r <= b;
                op_r   <= op;
                cnt_r  <= '0;
            end else if (state_r == ST_RUN) begin
                a_sh_r   <= a_sh_r >> 1;
                b_sh_r   <= b_sh_r >> 1;
                res_sh_r <= result_next_s;
                // The counter parks at its last value so it never wraps.
                if (!last_s) cnt_r <= cnt_r + CW'(1);
                if (last_s)  out_r <= result_next_s;
            end
        end
    end

    assign out  = out_r;
    assign busy = busy_r;
    assign done = done_r;
    assign zero = ~|out_r;

endmodule

// File: tb/tb_cl_serial_ctrl.sv
// Self-checking bench for cl_serial_ctrl: directed scenarios plus randomized
// operations compared against a whole-word reference model.
module tb_cl_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] out;
    logic         busy;
    logic         done;
    logic         zero;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] last_out;

    cl_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op),
        .out(out), .busy(busy), .done(done), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~x;
        endcase
    endfunction

    // Drives one operation from a falling edge and records what the DUT shows
    // in each of the W+1 cycles after the accepting edge.
    task automatic apply_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [1:0] ov,
                            input bit hold, input bit disturb, input logic [W-1:0] prev,
                            output int dk, output int pulses, output int busy_cnt,
                            output int held_bad, output logic busy_after,
                            output logic [W-1:0] res, output logic z);
        start = 1'b1; a = av; b = bv; op = ov;
        @(posedge clk);
        dk = 0; pulses = 0; busy_cnt = 0; held_bad = 0; busy_after = 1'bx; res = '0; z = 1'bx;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            if (k <= W) begin
                if (busy === 1'b1) busy_cnt++;
                if (out !== prev)  held_bad++;
            end else begin
                busy_after = busy;
            end
            if (done === 1'b1) begin
                pulses++;
                if (dk == 0) begin dk = k; res = out; z = zero; end
            end
            if (k == 1) begin
                if (!hold) start = 1'b0;
                a = W'($urandom); b = W'($urandom); op = 2'($urandom);
            end
            if (disturb && k == 3) begin a = '0; b = '0; op = 2'b00; start = 1'b1; end
            if (disturb && k == 4) start = hold;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0; op = 2'b00;
        repeat (2) @(negedge clk);
        vectors += 4;
        if (out !== '0)    begin miscompares++; $display("FAIL reset_out: got %h want 00", out); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        if (zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero: got %b want 1", zero); end
        start = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_start_ignored: busy got %b want 0", busy); end
        reset = 1'b0;
        last_out = '0;
    endtask

    task automatic test_basic();
        int dk, pl, bc, hb; logic ba, z; logic [W-1:0] r, e;
        e = model(8'hF0, 8'h3C, 2'b00);
        apply_op(8'hF0, 8'h3C, 2'b00, 1'b0, 1'b0, last_out, dk, pl, bc, hb, ba, r, z);
        vectors += 7;
        if (dk !== W + 1) begin miscompares++; $display("FAIL basic_latency: got %0d want %0d", dk, W + 1); end
        if (pl !== 1)     begin miscompares++; $display("FAIL basic_pulses: got %0d want 1", pl); end
        if (bc !== W)     begin miscompares++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, W); end
        if (hb !== 0)     begin miscompares++; $display("FAIL basic_out_held: got %0d changes want 0", hb); end
        if (ba !== 1'b0)  begin miscompares++; $display("FAIL basic_busy_in_done: got %b want 0", ba); end
        if (r !== e)      begin miscompares++; $display("FAIL basic_out: got %h want %h", r, e); end
        if (z !== 1'b0)   begin miscompares++; $display("FAIL basic_zero: got %b want 0", z); end
        last_out = e;
        repeat (3) @(negedge clk);
        vectors++;
        if (out !== 8'h30) begin miscompares++; $display("FAIL basic_hold: got %h want 30", out); end
    endtask

    task automatic test_ops();
        logic [W-1:0] bt [4] = '{8'h55, 8'hFF, 8'h12, 8'h55};
        logic [W-1:0] at [4] = '{8'hAA, 8'hAA, 8'hAA, 8'hAA};
        logic [1:0]   ot [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        int dk, pl, bc, hb; logic ba, z; logic [W-1:0] r, e;
        for (int i = 0; i < 4; i++) begin
            e = model(at[i], bt[i], ot[i]);
            apply_op(at[i], bt[i], ot[i], 1'b0, 1'b0, last_out, dk, pl, bc, hb, ba, r, z);
            vectors += 5;
            if (dk !== W + 1 || pl !== 1) begin miscompares++; $display("FAIL ops%0d_done: at cycle %0d pulses %0d want %0d/1", i, dk, pl, W + 1); end
            if (bc !== W || ba !== 1'b0)  begin miscompares++; $display("FAIL ops%0d_busy: got %0d/%b want %0d/0", i, bc, ba, W); end
            if (hb !== 0)                 begin miscompares++; $display("FAIL ops%0d_out_held: got %0d changes want 0", i, hb); end
            if (r !== e)                  begin miscompares++; $display("FAIL ops%0d_out: got %h want %h", i, r, e); end
            if (z !== (e == '0))          begin miscompares++; $display("FAIL ops%0d_zero: got %b want %b", i, z, (e == '0)); end
            last_out = e;
        end
    endtask

    task automatic test_ignore_start();
        int dk, pl, bc, hb; logic ba, z; logic [W-1:0] r;
        apply_op(8'h0F, 8'hF0, 2'b01, 1'b0, 1'b1, last_out, dk, pl, bc, hb, ba, r, z);
        vectors += 4;
        if (dk !== W + 1 || pl !== 1) begin miscompares++; $display("FAIL ignore_done: at cycle %0d pulses %0d want %0d/1", dk, pl, W + 1); end
        if (bc !== W)                 begin miscompares++; $display("FAIL ignore_busy: got %0d want %0d", bc, W); end
        if (r !== 8'hFF)              begin miscompares++; $display("FAIL ignore_out: got %h want ff", r); end
        if (hb !== 0)                 begin miscompares++; $display("FAIL ignore_out_held: got %0d changes want 0", hb); end
        last_out = 8'hFF;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_no_restart: busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int dk, pl, bc, hb; logic ba, z; logic [W-1:0] r;
        for (int i = 0; i < 3; i++) begin
            apply_op(8'h0F, 8'h0F, 2'b10, 1'b1, 1'b0, last_out, dk, pl, bc, hb, ba, r, z);
            vectors += 4;
            if (dk !== W + 1 || pl !== 1) begin miscompares++; $display("FAIL b2b%0d_spacing: at cycle %0d pulses %0d want %0d/1", i, dk, pl, W + 1); end
            if (bc !== W || ba !== 1'b0)  begin miscompares++; $display("FAIL b2b%0d_busy: got %0d/%b want %0d/0", i, bc, ba, W); end
            if (r !== 8'h00)              begin miscompares++; $display("FAIL b2b%0d_out: got %h want 00", i, r); end
            if (z !== 1'b1)               begin miscompares++; $display("FAIL b2b%0d_zero: got %b want 1", i, z); end
            last_out = 8'h00;
        end
        // start is still high here, so the DONE edge must go straight to RUN.
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_no_idle: busy got %b want 1", busy); end
        repeat (W + 1) @(negedge clk);
        last_out = model(a, b, op);
    endtask

    task automatic test_reset_abort();
        int dk, pl, bc, hb, seen; logic ba, z; logic [W-1:0] r;
        apply_op(8'h01, 8'h00, 2'b01, 1'b0, 1'b0, last_out, dk, pl, bc, hb, ba, r, z);
        vectors++;
        if (r !== 8'h01) begin miscompares++; $display("FAIL abort_pre_out: got %h want 01", r); end
        start = 1'b1; a = 8'hFF; b = 8'hFF; op = 2'b11;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors += 4;
        if (out !== '0)    begin miscompares++; $display("FAIL abort_out: got %h want 00", out); end
        if (zero !== 1'b1) begin miscompares++; $display("FAIL abort_zero: got %b want 1", zero); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b want 0", done); end
        seen = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (k == 1) reset = 1'b0;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen); end
        apply_op(8'hFF, 8'hFF, 2'b00, 1'b0, 1'b0, 8'h00, dk, pl, bc, hb, ba, r, z);
        vectors += 2;
        if (dk !== W + 1 || hb !== 0) begin miscompares++; $display("FAIL abort_after_done: at cycle %0d held-bad %0d want %0d/0", dk, hb, W + 1); end
        if (r !== 8'hFF)              begin miscompares++; $display("FAIL abort_after_out: got %h want ff", r); end
        last_out = 8'hFF;
    endtask

    task automatic test_random();
        int dk, pl, bc, hb; logic ba, z, hold; logic [W-1:0] r, e, av, bv; logic [1:0] ov;
        for (int i = 0; i < 40; i++) begin
            av = W'($urandom); bv = W'($urandom); ov = 2'($urandom);
            if (i % 8 == 0) av = (i % 16 == 0) ? 8'h00 : 8'hFF;
            hold = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
            e = model(av, bv, ov);
            apply_op(av, bv, ov, hold, 1'b0, last_out, dk, pl, bc, hb, ba, r, z);
            vectors += 4;
            if (dk !== W + 1 || pl !== 1) begin miscompares++; $display("FAIL rand%0d_done: at cycle %0d pulses %0d want %0d/1", i, dk, pl, W + 1); end
            if (bc !== W || hb !== 0)     begin miscompares++; $display("FAIL rand%0d_busy_hold: got %0d/%0d want %0d/0", i, bc, hb, W); end
            if (r !== e)                  begin miscompares++; $display("FAIL rand%0d_out: a=%h b=%h op=%0d got %h want %h", i, av, bv, ov, r, e); end
            if (z !== (e == '0))          begin miscompares++; $display("FAIL rand%0d_zero: got %b want %b", i, z, (e == '0)); end
            last_out = e;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ops();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cl_serial_ctrl.md
# cl_serial_ctrl

Bit-serial logic unit controller. It takes two WIDTH-bit operands and a 2-bit operation code, then sequences them LSB-first through one shared single-bit logic cell, one bit per clock. The cell implements and/or/xor/not-a selected by a 2-bit code. The controller assembles the WIDTH-bit result and reports completion with a busy/done handshake. It sits between the register file / control path and the single-bit logic cell of the ALU datapath, trading WIDTH cycles of latency for one cell instance.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces all state to reset values immediately.
- start  input  1  request to begin an operation; sampled on rising clk edges.
- a  input  WIDTH  operand A; sampled only on the accepting edge.
- b  input  WIDTH  operand B; sampled only on the accepting edge.
- op  input  2  operation: 00 and, 01 or, 10 xor, 11 not a (b ignored). Sampled only on the accepting edge.
- out  output  WIDTH  result register; holds the last completed result.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; out is valid and new in this cycle.
- zero  output  1  equals ~|out; combinational from the out register.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values:
  - out = 0
  - busy = 0
  - done = 0
  - zero = 1
  - bit counter = 0
  - operand shift registers = 0
  - op register = 00
- Accepting edge: start = 1 while state is IDLE or DONE.
  - a, b and op are latched into internal registers.
  - Counter is cleared to 0; state goes to RUN.
- start in RUN is ignored; the in-flight operation continues unchanged.
- RUN: each cycle the logic cell is fed bit 0 of the A and B shift registers plus the latched op.
  - The cell's output bit shifts into the MSB of the result shift register.
  - The A and B shift registers shift right by one.
  - The counter increments.
- On the edge where the counter reaches WIDTH-1 (the WIDTH-th RUN edge):
  - The complete result shift register is copied to out.
  - State goes to DONE.
- DONE lasts exactly one cycle. Without start it returns to IDLE; with start it goes directly to RUN as a new accepted operation.
- out changes only on the RUN→DONE edge and on reset. The previous result stays visible during RUN.
- Changes on a, b or op after the accepting edge have no effect on the current operation.
- The single logic cell is the only place results are computed. There is no parallel WIDTH-bit logic path.
- Counter width: ceil(log2(WIDTH)) bits. It must not wrap before completion.

## Timing
- Call the accepting edge E0.
- busy = 1 from E0 through E(WIDTH-1); it goes 0 on the edge E(WIDTH).
  - More exactly, busy is 1 in the WIDTH cycles following E0.
  - busy is 0 in the DONE cycle.
- done = 1 for exactly the one cycle after edge E(WIDTH), which is the DONE state. out and zero are updated at that same edge.
- Latency: start-to-done = WIDTH+1 edges, counting E0. Throughput: one result per WIDTH+1 cycles back-to-back (start held high).
- Reset asserted mid-RUN:
  - Aborts immediately; no done pulse.
  - out is cleared to 0 and busy to 0.
  - After release the block is IDLE and accepts start on the first rising edge.
- start high during reset release: no capture until the first rising edge with reset low.

## Test plan
- WIDTH=8, a=0xF0, b=0x3C, op=00, 1-cycle start -> busy for 8 cycles, done 1 cycle later with out=0x30 and zero=0. out holds 0x30 afterwards.
- Sequence of ops with a=0xAA:
  - op=01, b=0x55 -> out=0xFF
  - op=10, b=0xFF -> out=0x55
  - op=11, b=0x12 -> out=0x55 (b ignored)
  - Each done pulse arrives exactly 9 edges after its accepting edge.
- op=00, a=0xAA, b=0x55 -> out=0x00 and zero=1 at done.
- Start with a=0x0F, b=0xF0, op=01, then during RUN:
  - Drive a=0, b=0 and op=00.
  - Pulse start again.
  - Required: out=0xFF, a single done pulse, busy never drops early.
- Hold start high continuously with a=0x0F, b=0x0F, op=10 -> DONE is followed immediately by RUN (no IDLE cycle). Each done shows out=0x00, zero=1, spaced 9 cycles apart.
- Let op=01, a=0x01, b=0x00 complete, giving out=0x01. Start a new operation, then assert reset on its 4th RUN cycle -> out=0, zero=1, busy=0, done never pulses. After release, a new op=00 with a=b=0xFF gives out=0xFF.
